// File: rtl/weather_sensor_rx.sv
// weather_sensor_rx: serial weather-frame receiver (start, 17 payload bits MSB first, even parity, stop)
// with atomic output commit, saturating error count and stale-data flag. Rev 1.0
`default_nettype none

module weather_sensor_rx #(
   parameter int STALE_LIMIT = 1000,
   parameter int ERR_W       = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              bit_valid,
   input  logic              sdata,
   output logic              thunderstorm,
   output logic [5:0]        wind,
   output logic [1:0]        visibility,
   output logic signed [7:0] temperature,
   output logic              frame_valid,
   output logic              frame_error,
   output logic              data_stale,
   output logic [ERR_W-1:0]  err_count,
   output logic [1:0]        rx_state
);

   localparam int             SW        = $clog2(STALE_LIMIT + 1);
   localparam logic [SW-1:0]  STALE_MAX = SW'(STALE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t          state;
   logic [4:0]      bit_cnt;
   logic [16:0]     payload;
   logic            parity_bit;
   logic [SW-1:0]   stale_cnt;
   logic            seen_good;
   logic            parity_ok;
   logic            commit;

   assign parity_ok  = ~^{payload, parity_bit};
   assign commit     = bit_valid && (state == STOP) && sdata && parity_ok;
   assign data_stale = (stale_cnt == STALE_MAX) || !seen_good;
   assign rx_state   = state;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         payload      <= '0;
         parity_bit   <= 1'b0;
         stale_cnt    <= '0;
         seen_good    <= 1'b0;
         thunderstorm <= 1'b0;
         wind         <= '0;
         visibility   <= '0;
         temperature  <= '0;
         frame_valid  <= 1'b0;
         frame_error  <= 1'b0;
         err_count    <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;

         if (commit)
            stale_cnt <= '0;
         else if (stale_cnt != STALE_MAX)
            stale_cnt <= stale_cnt + 1'b1;

         if (bit_valid) begin
            case (state)
               IDLE: begin
                  if (!sdata) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  payload <= {payload[15:0], sdata};
                  if (bit_cnt == 5'd16)
                     state <= PARITY;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: begin
                  parity_bit <= sdata;
                  state      <= STOP;
               end
               STOP: begin
                  // Outputs move only here, so a partial payload never leaks out.
                  if (sdata && parity_ok) begin
                     thunderstorm <= payload[16];
                     wind         <= payload[15:10];
                     visibility   <= payload[9:8];
                     temperature  <= payload[7:0];
                     frame_valid  <= 1'b1;
                     seen_good    <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                     if (err_count != '1)
                        err_count <= err_count + 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_weather_sensor_rx.sv
// tb_weather_sensor_rx: directed self-checking bench for weather_sensor_rx. Rev 1.0
`default_nettype none

module tb_weather_sensor_rx;

   localparam int LIM = 40;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              bit_valid = 1'b0;
   logic              sdata = 1'b1;
   logic              thunderstorm;
   logic [5:0]        wind;
   logic [1:0]        visibility;
   logic signed [7:0] temperature;
   logic              frame_valid;
   logic              frame_error;
   logic              data_stale;
   logic [7:0]        err_count;
   logic [1:0]        rx_state;

   int total = 0;
   int bad   = 0;
   int fv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;

   weather_sensor_rx #(.STALE_LIMIT(LIM), .ERR_W(8)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .bit_valid    (bit_valid),
      .sdata        (sdata),
      .thunderstorm (thunderstorm),
      .wind         (wind),
      .visibility   (visibility),
      .temperature  (temperature),
      .frame_valid  (frame_valid),
      .frame_error  (frame_error),
      .data_stale   (data_stale),
      .err_count    (err_count),
      .rx_state     (rx_state)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (frame_valid) fv_cnt++;
      if (frame_error) fe_cnt++;
      if (frame_valid && frame_error) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One bit per cycle: present on the falling edge, sampled by the next rising edge.
   task automatic strobe(input logic b);
      @(negedge CLK);
      bit_valid = 1'b1;
      sdata     = b;
      @(posedge CLK);
      #1;
      bit_valid = 1'b0;
      sdata     = 1'b1;
   endtask

   task automatic send_frame(input logic [16:0] p, input logic par, input logic stp);
      strobe(1'b0);
      for (int i = 16; i >= 0; i--) strobe(p[i]);
      strobe(par);
      strobe(stp);
   endtask

   task automatic check_outputs(input string tag, input logic ts, input logic [5:0] w,
                                input logic [1:0] v, input logic [7:0] t);
      check({tag, "_thunder"}, {31'd0, thunderstorm}, {31'd0, ts});
      check({tag, "_wind"},    {26'd0, wind},         {26'd0, w});
      check({tag, "_vis"},     {30'd0, visibility},   {30'd0, v});
      check({tag, "_temp"},    {24'd0, temperature},  {24'd0, t});
   endtask

   initial begin
      // Reset values while RST is low
      #12;
      check_outputs("rst", 1'b0, 6'd0, 2'd0, 8'd0);
      check("rst_fv",    {31'd0, frame_valid}, 32'd0);
      check("rst_fe",    {31'd0, frame_error}, 32'd0);
      check("rst_stale", {31'd0, data_stale},  32'd1);
      check("rst_err",   {24'd0, err_count},   32'd0);
      check("rst_state", {30'd0, rx_state},    32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // Idle-high line with strobes must not start a frame
      strobe(1'b1);
      check("idle_stay", {30'd0, rx_state}, 32'd0);

      // Frame 1: ts=0 wind=12 vis=0 temp=25
      fv_cnt = 0;
      send_frame(17'b0_001100_00_00011001, 1'b1, 1'b1);
      check("f1_fv", {31'd0, frame_valid}, 32'd1);
      check("f1_stale", {31'd0, data_stale}, 32'd0);
      check_outputs("f1", 1'b0, 6'd12, 2'd0, 8'd25);
      @(posedge CLK); #1;
      check("f1_fv_drop", {31'd0, frame_valid}, 32'd0);
      check("f1_fv_pulses", fv_cnt, 32'd1);

      // Frame 2: ts=1 wind=25 vis=2 temp=-40
      send_frame(17'b1_011001_10_11011000, 1'b1, 1'b1);
      check("f2_fv", {31'd0, frame_valid}, 32'd1);
      check_outputs("f2", 1'b1, 6'd25, 2'd2, 8'hD8);

      // Bad parity, then stop=0: outputs hold, two error pulses
      fe_cnt = 0;
      send_frame(17'h00000, 1'b1, 1'b1);
      check("bp_fe", {31'd0, frame_error}, 32'd1);
      check("bp_fv", {31'd0, frame_valid}, 32'd0);
      check("bp_err", {24'd0, err_count}, 32'd1);
      send_frame(17'b0_001100_00_00011001, 1'b1, 1'b0);
      check("bs_fe", {31'd0, frame_error}, 32'd1);
      check_outputs("bad_hold", 1'b1, 6'd25, 2'd2, 8'hD8);
      @(posedge CLK); #1;
      check("bad_pulses", fe_cnt, 32'd2);
      check("bad_err", {24'd0, err_count}, 32'd2);

      // Stale after exactly LIM cycles following a commit
      send_frame(17'b0_001100_00_00011001, 1'b1, 1'b1);
      check("st_commit", {31'd0, data_stale}, 32'd0);
      repeat (LIM - 1) @(posedge CLK);
      #1;
      check("st_before", {31'd0, data_stale}, 32'd0);
      @(posedge CLK); #1;
      check("st_at", {31'd0, data_stale}, 32'd1);
      repeat (5) @(posedge CLK);
      #1;
      check("st_hold", {31'd0, data_stale}, 32'd1);
      send_frame(17'b1_011001_10_11011000, 1'b1, 1'b1);
      check("st_clear", {31'd0, data_stale}, 32'd0);

      // Reset mid-frame after 10 payload bits
      fe_cnt = 0;
      strobe(1'b0);
      for (int i = 0; i < 10; i++) strobe(1'b1);
      check("mid_state", {30'd0, rx_state}, 32'd1);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check_outputs("mid_rst", 1'b0, 6'd0, 2'd0, 8'd0);
      check("mid_state_rst", {30'd0, rx_state}, 32'd0);
      check("mid_stale", {31'd0, data_stale}, 32'd1);
      check("mid_err_rst", {24'd0, err_count}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      send_frame(17'b0_001100_00_00011001, 1'b1, 1'b1);
      check_outputs("mid_new", 1'b0, 6'd12, 2'd0, 8'd25);
      check("mid_err", {24'd0, err_count}, 32'd0);
      check("mid_no_fe", fe_cnt, 32'd0);

      // Error counter saturation
      for (int k = 0; k < 255; k++) send_frame(17'h00000, 1'b1, 1'b1);
      check("sat_255", {24'd0, err_count}, 32'd255);
      send_frame(17'h00000, 1'b0, 1'b0);
      check("sat_fe", {31'd0, frame_error}, 32'd1);
      check("sat_hold", {24'd0, err_count}, 32'd255);
      check_outputs("sat_keep", 1'b0, 6'd12, 2'd0, 8'd25);
      @(posedge CLK); #1;
      check("never_both", both_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/weather_sensor_rx.md
WEATHER_SENSOR_RX -- requirements
Module: weather_sensor_rx

Interface
REQ-001 Parameter STALE_LIMIT, default 1000; number of CLK cycles without a good frame before data is flagged stale.
REQ-002 Parameter ERR_W, default 8; width of the frame-error counter.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset; asserts immediately when low, state leaves reset on the first CLK rising edge after RST returns high.
REQ-005 bit_valid  input  1  strobe; sdata is sampled only on edges where bit_valid=1.
REQ-006 sdata  input  1  serial sensor line, idle high.
REQ-007 thunderstorm  output  1  last good thunderstorm flag.
REQ-008 wind  output  6  last good wind speed, unsigned.
REQ-009 visibility  output  2  last good visibility code.
REQ-010 temperature  output  8  last good temperature, signed two's complement.
REQ-011 frame_valid  output  1  one-cycle pulse on a good frame commit.
REQ-012 frame_error  output  1  one-cycle pulse on a rejected frame.
REQ-013 data_stale  output  1  high while weather outputs are older than STALE_LIMIT cycles or never written.
REQ-014 err_count  output  ERR_W  saturating count of rejected frames.
REQ-015 rx_state  output  2  current FSM state encoding.

Function
REQ-016 Frame format SHALL be: start bit 0, 17 payload bits MSB first, one even-parity bit, stop bit 1; one bit per bit_valid strobe.
REQ-017 Payload mapping SHALL be bit16 thunderstorm, bits15:10 wind, bits9:8 visibility, bits7:0 temperature.
REQ-018 Parity SHALL be even: the count of ones over the 17 payload bits plus the parity bit is even.
REQ-019 FSM states SHALL be IDLE=0, DATA=1, PARITY=2, STOP=3.
REQ-020 IDLE: a strobe with sdata=0 goes to DATA with the bit counter at 0; a strobe with sdata=1 stays in IDLE.
REQ-021 DATA: each strobe shifts sdata into the payload register; the 17th strobe goes to PARITY.
REQ-022 PARITY: a strobe captures the parity bit and goes to STOP.
REQ-023 STOP, sdata=1 with parity good: on the same rising edge, all four weather outputs update atomically, frame_valid=1 for exactly one cycle, and the FSM goes to IDLE.
REQ-024 STOP, sdata=0 or parity bad: weather outputs are held, frame_error=1 for one cycle, err_count increments, and the FSM goes to IDLE.
REQ-025 When err_count is at 2^ERR_W-1 it SHALL hold that value; frame_error still pulses.
REQ-026 Cycles with bit_valid=0 SHALL leave FSM, counters and payload unchanged; the stale counter still advances.
REQ-027 Stale counter: increments every cycle, saturates at STALE_LIMIT, and clears to 0 on a frame_valid commit.
REQ-028 data_stale SHALL equal (stale counter == STALE_LIMIT) OR no good frame since reset.
REQ-029 A good frame SHALL clear data_stale on the commit edge.
REQ-030 frame_valid and frame_error SHALL never be high in the same cycle.
REQ-031 Partial payload bits SHALL never reach the outputs.

Reset
REQ-032 With RST low: thunderstorm=0, wind=0, visibility=0, temperature=0, frame_valid=0, frame_error=0, err_count=0, stale counter=0, data_stale=1, rx_state=IDLE.
REQ-033 RST asserted mid-frame SHALL discard the partial frame without a frame_error pulse; the outputs take the reset values.

Verification
REQ-034 Reset, then frame with payload 0_001100_00_00011001 and parity 1 -> thunderstorm=0, wind=12, visibility=0, temperature=25; one frame_valid pulse; data_stale falls.
REQ-035 Frame with payload 1_011001_10_11011000 and parity 1 -> thunderstorm=1, wind=25, visibility=2, temperature=-40.
REQ-036 Frame with wrong parity, then a frame with stop=0 -> outputs hold their prior values; two frame_error pulses; err_count=2.
REQ-037 No frames for STALE_LIMIT cycles after a good frame -> data_stale=1 exactly STALE_LIMIT cycles after the commit; the next good frame clears it.
REQ-038 RST low after 10 payload bits, then a full good frame -> no frame_error; outputs are reset values, then the new frame values; err_count=0.
REQ-039 Drive 256 bad frames with ERR_W=8 -> err_count saturates at 255.
